// File: rtl/booth_mul_pkg.sv
// Shared constants, FSM states and operand payload for the Booth multiplier arbiter.
package booth_mul_pkg;

  localparam int unsigned MUL_WIDTH  = 16;
  localparam int unsigned ACC_WIDTH  = MUL_WIDTH + 1;
  localparam int unsigned PROD_WIDTH = 2 * MUL_WIDTH;
  localparam int unsigned STEP_COUNT = 16;
  localparam int unsigned CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [MUL_WIDTH-1:0] mcand;
    logic [MUL_WIDTH-1:0] mplier;
  } operands_t;

endpackage

// File: rtl/booth_mul_datapath.sv
// Radix-2 Booth datapath: 17-bit accumulator A, multiplier Q, Q(-1) and multiplicand.
module booth_mul_datapath
  import booth_mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  step_i,
  input  operands_t             ops_i,
  output logic [PROD_WIDTH-1:0] step_prod_c_o
);

  logic [ACC_WIDTH-1:0] a_q, a_d;
  logic [MUL_WIDTH-1:0] q_q, q_d;
  logic [MUL_WIDTH-1:0] m_q, m_d;
  logic                 qm1_q, qm1_d;

  logic [ACC_WIDTH-1:0] m_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] a_shift;
  logic [MUL_WIDTH-1:0] q_shift;

  // One Booth step (add/sub then arithmetic shift) and register next-state
  always_comb begin
    m_ext = {m_q[MUL_WIDTH-1], m_q};
    sum   = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
    a_shift       = {sum[ACC_WIDTH-1], sum[ACC_WIDTH-1:1]};
    q_shift       = {sum[0], q_q[MUL_WIDTH-1:1]};
    // Low 32 bits of {A,Q} after this step; valid as the product on the last step
    step_prod_c_o = {a_shift[MUL_WIDTH-1:0], q_shift};

    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    qm1_d = qm1_q;
    if (load_i) begin
      a_d   = '0;
      q_d   = ops_i.mplier;
      m_d   = ops_i.mcand;
      qm1_d = 1'b0;
    end else if (step_i) begin
      a_d   = a_shift;
      q_d   = q_shift;
      qm1_d = q_q[0];
    end
  end

  // Datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      qm1_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      qm1_q <= qm1_d;
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential 16x16 signed Booth multiplier among N_REQ requesters.
module booth_mul_arbiter
  import booth_mul_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0][MUL_WIDTH-1:0]     req_multiplicand,
  input  logic [N_REQ-1:0][MUL_WIDTH-1:0]     req_multiplier,
  output logic [N_REQ-1:0]                    req_ready,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(N_REQ)-1:0]            rsp_id,
  output logic [PROD_WIDTH-1:0]               rsp_product,
  output logic                                busy
);

  localparam int unsigned ID_WIDTH = $clog2(N_REQ);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic [PROD_WIDTH-1:0] rsp_product_q, rsp_product_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;

  logic [N_REQ-1:0]      grant_c;
  logic [ID_WIDTH-1:0]   grant_idx_c;
  logic                  accept_c;
  logic                  dp_load_c;
  logic                  dp_step_c;
  operands_t             ops_c;
  logic [PROD_WIDTH-1:0] dp_prod_c;

  // Round-robin pick: scan from farthest to ptr_q so the entry at ptr_q (highest priority) wins last
  always_comb begin
    int unsigned         idx;
    logic [ID_WIDTH-1:0] sel;
    idx         = 0;
    sel         = '0;
    grant_c     = '0;
    grant_idx_c = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      idx = 32'(ptr_q) + (N_REQ - 1 - j);
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = ID_WIDTH'(idx);
      if (req_valid[sel]) begin
        grant_c      = '0;
        grant_c[sel] = 1'b1;
        grant_idx_c  = sel;
      end
    end
  end

  // Grant only while idle, out of reset and not being flushed
  assign req_ready  = (state_q == ST_IDLE && rst && !flush) ? grant_c : '0;
  assign accept_c   = |(req_valid & req_ready);
  assign ops_c.mcand  = req_multiplicand[grant_idx_c];
  assign ops_c.mplier = req_multiplier[grant_idx_c];

  // Next-state and control: flush overrides acceptance and the response handshake
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    dp_load_c     = 1'b0;
    dp_step_c     = 1'b0;

    if (flush) begin
      state_d       = ST_IDLE;
      rsp_id_d      = '0;
      rsp_product_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            state_d   = ST_CALC;
            cnt_d     = '0;
            id_d      = grant_idx_c;
            dp_load_c = 1'b1;
            ptr_d     = (grant_idx_c == ID_WIDTH'(N_REQ - 1)) ? '0
                                                              : grant_idx_c + ID_WIDTH'(1);
          end
        end
        ST_CALC: begin
          dp_step_c = 1'b1;
          cnt_d     = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(STEP_COUNT - 1)) begin
            state_d       = ST_DONE;
            rsp_id_d      = id_q;
            rsp_product_d = dp_prod_c;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_d       = ST_IDLE;
            rsp_id_d      = '0;
            rsp_product_d = '0;
          end
        end
        default: begin
          state_d       = ST_IDLE;
          rsp_id_d      = '0;
          rsp_product_d = '0;
        end
      endcase
    end

    rsp_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      id_q          <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
    end
  end

  booth_mul_datapath u_datapath (
    .clk           (clk),
    .rst           (rst),
    .load_i        (dp_load_c),
    .step_i        (dp_step_c),
    .ops_i         (ops_c),
    .step_prod_c_o (dp_prod_c)
  );

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: directed vectors, monitor checks responses on rsp_valid rise.
module tb_booth_mul_arbiter;

  localparam int unsigned N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              rsp_ready;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][15:0] mcand;
  logic [N-1:0][15:0] mplier;
  logic              rsp_valid;
  logic              busy;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_product;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] prod;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_v = 1'b0;

  int          rr_order [5] = '{0, 1, 2, 3, 0};
  logic [31:0] rr_prod  [4] = '{32'h0000000F, 32'hFFFFFFF4, 32'hFFF0BDC0, 32'h0000FE01};

  booth_mul_arbiter #(.N_REQ(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_multiplicand (mcand),
    .req_multiplier   (mplier),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_product      (rsp_product),
    .busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: interface invariants every cycle, scoreboard pop on each response
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (req_ready != '0) check("ready_only_idle", 32'(busy), 32'd0);
      if (!rsp_valid) begin
        check("rsp_product_idle", rsp_product, 32'd0);
        check("rsp_id_idle", 32'(rsp_id), 32'd0);
      end
      if (rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_product", rsp_product, e.prod);
          check("rsp_latency", 32'(cyc - e.acc), 32'd16);
        end
      end
    end
    prev_v = rsp_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input logic [31:0] p);
    exp_t e;
    e.id   = 2'(id);
    e.prod = p;
    e.acc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic grant_wait(input int id, input string name);
    int n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(req_ready), 32'(1) << id);
  endtask

  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string name);
    mcand[id]     = a;
    mplier[id]    = b;
    req_valid[id] = 1'b1;
    grant_wait(id, name);
    push_exp(id, exp);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int k;
    int exp_id;

    // Reset with requests pending: everything must stay quiet
    rst = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    req_valid = '1; mcand = '0; mplier = '0;
    tick(3);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_product", rsp_product, 32'd0);
    req_valid = '0; rst = 1'b1;
    tick(1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);

    // Single directed products, including the extreme corners
    issue(2, 16'd7,    16'hFFFD, 32'hFFFFFFEB, "grant_r2");  wait_idle();
    issue(0, 16'h8000, 16'h8000, 32'h40000000, "grant_min"); wait_idle();
    issue(1, 16'h7FFF, 16'h8000, 32'hC0008000, "grant_mix"); wait_idle();
    issue(0, 16'hFFFF, 16'hFFFF, 32'h00000001, "grant_neg"); wait_idle();
    issue(3, 16'd100,  16'd200,  32'h00004E20, "grant_r3");  wait_idle();

    // All four requesters held valid: round-robin 0,1,2,3,0
    mcand[0] = 16'd3;    mplier[0] = 16'd5;
    mcand[1] = 16'hFFFE; mplier[1] = 16'd6;
    mcand[2] = 16'd1000; mplier[2] = 16'hFC18;
    mcand[3] = 16'd255;  mplier[3] = 16'd255;
    req_valid = '1;
    k = 0; n = 0;
    while (k < 5 && n < 400) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) begin
        exp_id = rr_order[k];
        check("rr_grant", 32'(req_ready), 32'(1) << exp_id);
        push_exp(exp_id, rr_prod[exp_id]);
        k++;
      end
    end
    check("rr_grant_count", 32'(k), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Back-pressure in DONE: outputs held, no grant until after the handshake
    issue(1, 16'd12, 16'd12, 32'h00000090, "grant_bp");
    rsp_ready = 1'b0;
    mcand[2] = 16'd2; mplier[2] = 16'd2; req_valid[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_product", rsp_product, 32'h00000090);
      check("hold_id", 32'(rsp_id), 32'd1);
      check("hold_no_grant", 32'(req_ready), 32'd0);
      if (i < 9) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pre_hs_no_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_grant", 32'(req_ready), 32'b0100);
    push_exp(2, 32'h00000004);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_idle();

    // Flush at step 8: back to IDLE, no response, next op fine
    issue(3, 16'd50, 16'd50, 32'h000009C4, "grant_flush");
    tick(7);
    flush = 1'b1;
    tick(1);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_valid", 32'(rsp_valid), 32'd0);
    flush = 1'b0;
    sb.delete();
    tick(20);
    issue(0, 16'hFFFB, 16'd9, 32'hFFFFFFD3, "grant_after_flush");
    wait_idle();

    // Reset mid-CALC: outputs cleared, pointer back to requester 0
    issue(1, 16'd7, 16'd7, 32'h00000031, "grant_pre_rst");
    tick(4);
    rst = 1'b0;
    tick(1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_id", 32'(rsp_id), 32'd0);
    check("midrst_product", rsp_product, 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    rst = 1'b1;
    mcand[3] = 16'd3; mplier[3] = 16'd3; req_valid[3] = 1'b1;
    issue(0, 16'd2, 16'hFFF8, 32'hFFFFFFF0, "rst_ptr_r0_wins");
    req_valid[3] = 1'b0;
    wait_idle();

    tick(5);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 SHALL have port req_multiplicand  input  N_REQ x 16  signed multiplicand per requester.
REQ-007 SHALL have port req_multiplier  input  N_REQ x 16  signed multiplier per requester.
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot grant; the request is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port rsp_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-012 SHALL have port rsp_product  output  32  signed product.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, CALC and DONE.
REQ-015 SHALL in IDLE drive at most one req_ready bit: the first requester with req_valid high, searching round-robin from the requester after the last grant.
REQ-016 SHALL on acceptance capture both operands and the id, clear the 5-bit step counter, clear the accumulator and Q(-1), and move to CALC.
REQ-017 SHALL in CALC perform one radix-2 Booth step per cycle: {Q0,Q-1}=01 adds the multiplicand, 10 subtracts it, 00/11 do nothing; then arithmetic-shift {A,Q,Q-1} right by 1.
REQ-018 SHALL use a 17-bit sign-extended accumulator so every signed pair is exact, including -32768 x -32768 = 0x40000000.
REQ-019 SHALL move from CALC to DONE on the edge that completes step 16, so rsp_valid rises exactly 16 cycles after the acceptance edge.
REQ-020 SHALL in DONE hold rsp_valid, rsp_id and rsp_product stable until rsp_ready is high at an edge, then return to IDLE.
REQ-021 SHALL NOT accept a new request in the same cycle as the response handshake; the earliest next acceptance is one cycle after returning to IDLE.
REQ-022 SHALL advance the round-robin pointer only on an accepted request; a dropped req_valid in IDLE without acceptance does not move it.
REQ-023 SHALL keep req_ready all-zero outside IDLE; req_valid may change freely while not granted.
REQ-024 SHALL on flush high return to IDLE at the next edge from any state, discarding the result without asserting rsp_valid; flush has priority over acceptance and the response handshake; the pointer is unchanged.
REQ-025 SHALL keep rsp_product at 0 and rsp_id at 0 whenever rsp_valid is low.

Reset
REQ-026 SHALL on rst low at an edge enter IDLE, clear the counter, operand registers, accumulator and Q(-1), and set the round-robin pointer so requester 0 has highest priority.
REQ-027 SHALL drive rsp_valid, req_ready, busy, rsp_id and rsp_product to 0 during and after reset until the first acceptance or grant.
REQ-028 SHALL on reset mid-CALC or mid-DONE abandon the operation with no response emitted.

Structure
REQ-029 SHALL place the state enum, MUL_WIDTH=16 and the step count 16 in the shared package booth_mul_pkg.
REQ-030 SHALL instantiate one sub-module, booth_mul_datapath, holding the accumulator, Q and Q(-1) registers and the add/sub/shift logic; arbitration and FSM stay in the top level.

Verification
REQ-031 SHALL cover: a single request from requester 2 with 7 x -3 -> accepted, rsp_valid 16 cycles later, product 0xFFFFFFEB, rsp_id 2.
REQ-032 SHALL cover: -32768 x -32768 -> 0x40000000; and 32767 x -32768 -> 0xC0008000.
REQ-033 SHALL cover: all 4 requesters held valid continuously -> grants in order 0,1,2,3,0; each req_ready is one-hot and asserted only in IDLE.
REQ-034 SHALL cover: rsp_ready held low for 10 cycles in DONE -> outputs stable, no new grant, and the next grant occurs one cycle after the handshake.
REQ-035 SHALL cover: flush asserted at step 8 -> IDLE next cycle, rsp_valid is never asserted, and the next request completes correctly.
REQ-036 SHALL cover: rst pulsed low mid-CALC -> all outputs 0 next cycle, and the pointer resets so requester 0 wins over requester 3.
